// File: rtl/tdc_seq_ctrl.sv
// tdc_seq_ctrl: power-up / resync sequencer for the external TDC clocks and RSTIDX pulse
module tdc_seq_ctrl #(
    parameter int SETTLE_CYCLES = 1024,
    parameter int RSTIDX_LEN    = 4,
    parameter int CNT_W         = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start_i,
    input  logic        stop_i,
    input  logic        resync_i,
    output logic        refclk_en_o,
    output logic        rstidx_o,
    output logic        lclki_en_o,
    output logic        ready_o,
    output logic        busy_o,
    output logic [2:0]  state_o,
    output logic [15:0] resync_cnt_o
);
    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        REF_SETTLE  = 3'd1,
        RSTIDX      = 3'd2,
        LCLK_SETTLE = 3'd3,
        RUN         = 3'd4,
        RESYNC      = 3'd5
    } state_t;
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RSTIDX_LD = CNT_W'(RSTIDX_LEN - 1);
    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [15:0]      r_resync_cnt;
    logic             r_refclk_en, r_rstidx, r_lclki_en, r_ready, r_busy;
    logic             w_cnt_zero, w_resync_done;
    logic             w_refclk_nxt, w_rstidx_nxt, w_lclki_nxt, w_ready_nxt, w_busy_nxt;
    assign w_cnt_zero = (r_cnt == '0);
    // Next-state and phase counter; stop_i overrides every state, start/resync only act in IDLE/RUN
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_resync_done = 1'b0;
        if (stop_i) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start_i) begin
                    w_state_nxt = REF_SETTLE;
                    w_cnt_nxt   = SETTLE_LD;
                end
                REF_SETTLE: if (w_cnt_zero) begin
                    w_state_nxt = RSTIDX;
                    w_cnt_nxt   = RSTIDX_LD;
                end else w_cnt_nxt = r_cnt - CNT_W'(1);
                RSTIDX: if (w_cnt_zero) begin
                    w_state_nxt = LCLK_SETTLE;
                    w_cnt_nxt   = SETTLE_LD;
                end else w_cnt_nxt = r_cnt - CNT_W'(1);
                LCLK_SETTLE: if (w_cnt_zero) w_state_nxt = RUN;
                else w_cnt_nxt = r_cnt - CNT_W'(1);
                RUN: if (resync_i) begin
                    w_state_nxt = RESYNC;
                    w_cnt_nxt   = RSTIDX_LD;
                end
                RESYNC: if (w_cnt_zero) begin
                    w_state_nxt   = RUN;
                    w_resync_done = 1'b1;
                end else w_cnt_nxt = r_cnt - CNT_W'(1);
                default: w_state_nxt = IDLE;
            endcase
        end
    end
    // Outputs are decoded from the next state so they register on the same edge as the state
    assign w_refclk_nxt = (w_state_nxt != IDLE);
    assign w_rstidx_nxt = (w_state_nxt == RSTIDX) || (w_state_nxt == RESYNC);
    assign w_lclki_nxt  = (w_state_nxt == LCLK_SETTLE) || (w_state_nxt == RUN) || (w_state_nxt == RESYNC);
    assign w_ready_nxt  = (w_state_nxt == RUN);
    assign w_busy_nxt   = (w_state_nxt != IDLE) && (w_state_nxt != RUN);
    // State, counter, registered outputs and saturating resync counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_refclk_en  <= 1'b0;
            r_rstidx     <= 1'b0;
            r_lclki_en   <= 1'b0;
            r_ready      <= 1'b0;
            r_busy       <= 1'b0;
            r_resync_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_refclk_en <= w_refclk_nxt;
            r_rstidx    <= w_rstidx_nxt;
            r_lclki_en  <= w_lclki_nxt;
            r_ready     <= w_ready_nxt;
            r_busy      <= w_busy_nxt;
            if (w_resync_done && r_resync_cnt != 16'hFFFF)
                r_resync_cnt <= r_resync_cnt + 16'd1;
        end
    end
    assign refclk_en_o  = r_refclk_en;
    assign rstidx_o     = r_rstidx;
    assign lclki_en_o   = r_lclki_en;
    assign ready_o      = r_ready;
    assign busy_o       = r_busy;
    assign state_o      = r_state;
    assign resync_cnt_o = r_resync_cnt;
endmodule

// File: tb/tb_tdc_seq_ctrl.sv
// tb_tdc_seq_ctrl: scoreboard bench for tdc_seq_ctrl with S=8, L=4
module tb_tdc_seq_ctrl;
    logic        clk = 1'b0, rstn = 1'b0, start_i = 1'b0, stop_i = 1'b0, resync_i = 1'b0;
    logic        refclk_en_o, rstidx_o, lclki_en_o, ready_o, busy_o;
    logic [2:0]  state_o;
    logic [15:0] resync_cnt_o;
    int errors = 0, checks = 0;
    typedef struct packed {
        logic [2:0]  st;
        logic        rf, rx, lk, rd, bs;
        logic [15:0] cnt;
    } vec_t;
    typedef struct {
        vec_t  v;
        string name;
    } exp_t;
    exp_t sb[$];

    tdc_seq_ctrl #(.SETTLE_CYCLES(8), .RSTIDX_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .rstn(rstn), .start_i(start_i), .stop_i(stop_i), .resync_i(resync_i),
        .refclk_en_o(refclk_en_o), .rstidx_o(rstidx_o), .lclki_en_o(lclki_en_o),
        .ready_o(ready_o), .busy_o(busy_o), .state_o(state_o), .resync_cnt_o(resync_cnt_o)
    );

    always #5 clk = ~clk;

    // Expected outputs for a given state code, from the per-state output table
    function automatic vec_t ex(input int s, input int c);
        vec_t v;
        v.st  = 3'(s);
        v.rf  = (s != 0);
        v.rx  = (s == 2) || (s == 5);
        v.lk  = (s == 3) || (s == 4) || (s == 5);
        v.rd  = (s == 4);
        v.bs  = (s == 1) || (s == 2) || (s == 3) || (s == 5);
        v.cnt = 16'(c);
        return v;
    endfunction

    function automatic vec_t act();
        vec_t v;
        v = {state_o, refclk_en_o, rstidx_o, lclki_en_o, ready_o, busy_o, resync_cnt_o};
        return v;
    endfunction

    function automatic string fmt(input vec_t v);
        return $sformatf("st=%0d ref=%b rstidx=%b lclk=%b rdy=%b busy=%b cnt=%0d",
                         v.st, v.rf, v.rx, v.lk, v.rd, v.bs, v.cnt);
    endfunction

    task automatic check(input vec_t e, input string name);
        vec_t a;
        a = act();
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s @%0t: actual %s, required %s", name, $time, fmt(a), fmt(e));
        end
    endtask

    // One cycle of stimulus; expectation is for the outputs after the coming edge
    task automatic cyc(input logic st, input logic sp, input logic rs,
                       input int s, input int c, input string name);
        exp_t e;
        @(negedge clk);
        start_i  = st;
        stop_i   = sp;
        resync_i = rs;
        e.v      = ex(s, c);
        e.name   = name;
        sb.push_back(e);
    endtask

    task automatic seg(input int n, input int s, input int c, input string name);
        repeat (n) cyc(1'b0, 1'b0, 1'b0, s, c, name);
    endtask

    task automatic drain();
        for (int i = 0; i < 5 && sb.size() != 0; i++) @(posedge clk);
        #2;
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: actual %0d pending, required 0", sb.size());
        end
    endtask

    // Monitor: compares DUT outputs 1ns after each edge against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(e.v, e.name);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 check(ex(0, 0), "reset");
        @(negedge clk) rstn = 1'b1;
        seg(2, 0, 0, "idle");
        cyc(1, 0, 0, 1, 0, "pu_start");
        seg(7, 1, 0, "pu_ref");
        seg(4, 2, 0, "pu_rstidx");
        seg(8, 3, 0, "pu_lclk");
        seg(3, 4, 0, "pu_run");
        cyc(0, 0, 1, 5, 0, "resync");
        seg(1, 5, 0, "resync_hold");
        cyc(0, 0, 1, 5, 0, "resync_dup");
        seg(1, 5, 0, "resync_hold");
        seg(3, 4, 1, "resync_done");
        cyc(1, 0, 0, 4, 1, "start_in_run");
        seg(1, 4, 1, "start_in_run");
        cyc(0, 1, 1, 0, 1, "stop_resync");
        seg(2, 0, 1, "idle_after_stop");
        cyc(0, 0, 1, 0, 1, "resync_in_idle");
        cyc(1, 1, 0, 0, 1, "start_stop");
        cyc(1, 1, 0, 0, 1, "start_stop_held");
        seg(1, 0, 1, "idle");
        cyc(1, 0, 0, 1, 1, "rs_start");
        seg(7, 1, 1, "rs_ref");
        seg(2, 2, 1, "rs_rstidx");
        cyc(0, 1, 0, 0, 1, "stop_rstidx");
        seg(2, 0, 1, "idle_after_stop");
        cyc(1, 0, 0, 1, 1, "re_start");
        seg(7, 1, 1, "re_ref");
        seg(4, 2, 1, "re_rstidx");
        seg(8, 3, 1, "re_lclk");
        seg(2, 4, 1, "re_run");
        cyc(1, 0, 0, 4, 1, "ar_start_ignored");
        cyc(0, 1, 0, 0, 1, "ar_stop");
        cyc(1, 0, 0, 1, 1, "ar_start");
        seg(7, 1, 1, "ar_ref");
        seg(4, 2, 1, "ar_rstidx");
        seg(3, 3, 1, "ar_lclk");
        drain();
        rstn = 1'b0;
        #1 check(ex(0, 0), "async_reset");
        repeat (2) @(posedge clk);
        #1 check(ex(0, 0), "reset_held");
        @(negedge clk) rstn = 1'b1;
        seg(4, 0, 0, "post_reset_idle");
        cyc(1, 0, 0, 1, 0, "post_reset_start");
        seg(1, 1, 0, "post_reset_ref");
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tdc_seq_ctrl.md
# tdc_seq_ctrl

Power-up and resynchronisation sequencer for the external TDC chip. It drives the enables for the TDC reference clock and the LVDS local clock, and generates the reset-index (RSTIDX) pulse, all through the differential output buffers. Software or the top-level FSM issues start, stop and resync commands. The block guarantees that clocks settle before RSTIDX fires and that the TDC is flagged ready only once the full sequence has completed.

## Interface
Parameters:
- SETTLE_CYCLES, 1024, clock-settle wait in clk cycles; applies to both settle phases; ≥1.
- RSTIDX_LEN, 4, RSTIDX high time in clk cycles; ≥1.
- CNT_W, 16, width of the internal down-counter; SETTLE_CYCLES and RSTIDX_LEN must each be < 2^CNT_W.

Ports:
- clk  in  1  system clock; the only clock.
- rstn  in  1  reset, asynchronous assert, active-low.
- start_i  in  1  single-cycle pulse; begins the power-up sequence from IDLE.
- stop_i  in  1  level or pulse; returns the block to IDLE.
- resync_i  in  1  single-cycle pulse; re-issues RSTIDX while in RUN.
- refclk_en_o  out  1  gate for the TDC reference clock.
- rstidx_o  out  1  RSTIDX level to the output buffer.
- lclki_en_o  out  1  gate for the TDC LVDS local clock.
- ready_o  out  1  TDC usable.
- busy_o  out  1  sequence in progress (any state other than IDLE or RUN).
- state_o  out  3  current state code.
- resync_cnt_o  out  16  number of completed resyncs; saturates at 0xFFFF.

## Operation
- All outputs are registered. While rstn=0, every output is 0 and the state is IDLE.
- State codes: IDLE=0, REF_SETTLE=1, RSTIDX=2, LCLK_SETTLE=3, RUN=4, RESYNC=5.
- IDLE: all enables low.
  - start_i → REF_SETTLE; the counter loads SETTLE_CYCLES-1.
- REF_SETTLE: refclk_en_o=1. The counter decrements each cycle.
  - At count 0 → RSTIDX; the counter loads RSTIDX_LEN-1.
- RSTIDX: refclk_en_o=1, rstidx_o=1.
  - At count 0 → LCLK_SETTLE; the counter loads SETTLE_CYCLES-1.
- LCLK_SETTLE: refclk_en_o=1, lclki_en_o=1, rstidx_o=0.
  - At count 0 → RUN.
- RUN: refclk_en_o=1, lclki_en_o=1, ready_o=1.
  - resync_i → RESYNC; the counter loads RSTIDX_LEN-1.
- RESYNC: both clock enables stay at 1, rstidx_o=1, ready_o=0.
  - At count 0 → RUN, and resync_cnt_o increments, saturating at 0xFFFF.
- Command priority: stop_i > start_i > resync_i.
  - stop_i in any state → IDLE on the next edge; all enables and ready_o drop on that edge.
  - If stop_i is held, the block stays in IDLE and start_i is ignored.
- start_i outside IDLE is ignored. resync_i outside RUN is ignored and is not queued.
- resync_cnt_o clears only on rstn. It is not cleared by stop_i or by re-running start_i.
- busy_o = 1 in REF_SETTLE, RSTIDX, LCLK_SETTLE and RESYNC.

## Timing
- Let S=SETTLE_CYCLES and L=RSTIDX_LEN. start_i is sampled at edge 0. Then:
  - refclk_en_o rises at edge 1.
  - rstidx_o is high from edge S+1 to edge S+L+1, i.e. exactly L cycles.
  - lclki_en_o rises at edge S+L+1.
  - ready_o rises at edge 2S+L+1.
- Resync: resync_i is sampled at edge 0.
  - ready_o falls and rstidx_o rises at edge 1.
  - rstidx_o falls and ready_o rises at edge L+1.
  - resync_cnt_o updates at edge L+1.
- rstidx_o never overlaps a state in which refclk_en_o=0.
- In the power-up sequence, lclki_en_o never rises before rstidx_o falls.
- Asynchronous reset mid-sequence: outputs go to 0 immediately, with no clock edge required. After release, the block waits in IDLE for a new start_i.

## Test plan
Bench parameters: S=8, L=4, CNT_W=8.
- Power-up: reset, then pulse start_i.
  - refclk_en_o at +1.
  - rstidx_o high for cycles +9..+12.
  - lclki_en_o at +13.
  - ready_o at +21.
  - state_o sequence 1,2,3,4; busy_o high for +1..+20.
- Resync in RUN: pulse resync_i.
  - rstidx_o high for 4 cycles and ready_o low for 4 cycles.
  - resync_cnt_o goes 0→1 at +5.
  - A second resync_i pulse during RESYNC is ignored: the count ends at 1.
- Stop mid-sequence: pulse stop_i during RSTIDX.
  - All outputs are 0 at the next edge and state_o=0.
  - A following start_i restarts the full 21-cycle sequence.
- Ignored commands:
  - start_i in RUN leaves state_o=4 and outputs unchanged.
  - resync_i in IDLE leaves state_o=0.
- Simultaneous commands: start_i and stop_i together in IDLE, and stop_i with resync_i in RUN.
  - In both cases state_o=0 and all outputs are 0.
- Async reset: assert rstn low mid-LCLK_SETTLE, between clock edges.
  - All outputs drop immediately and resync_cnt_o=0.
  - No output activity follows until start_i.
